multiword_add_sequencer: RTL and testbench

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/multiword_add_sequencer.sv | 170 +++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Adds two NWORDS x 16-bit operands one word per clock through a single
//   16-bit ripple-carry adder. A request is accepted in IDLE, the words are
//   summed low to high in RUN, and the result is held in HOLD until the
//   consumer takes it.
//   Optional feature: define MULTIWORD_ADD_SUB_EN to add the `sub` port,
//   which turns the operation into a - b (B inverted, initial carry forced 1).

module ripple_carry_adder_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    logic [16:0] w_c;

    // Bit-serial carry chain across the 16 bits.
    always_comb begin
        w_c    = '0;
        Sum    = '0;
        w_c[0] = Cin;
        for (int i = 0; i < 16; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ w_c[i];
            w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
        Cout = w_c[16];
    end

endmodule

module multiword_add_sequencer #(
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*NWORDS-1:0] a,
    input  logic [16*NWORDS-1:0] b,
    input  logic                 cin,
`ifdef MULTIWORD_ADD_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*NWORDS-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W  = 16 * NWORDS;
    localparam int KW = $clog2(NWORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_carry;
    logic [KW-1:0] r_k;
    logic          r_cout;
    logic          r_ovf;

    logic [W-1:0]  w_b_in;
    logic          w_cin_in;
    logic [15:0]   w_a_word;
    logic [15:0]   w_b_word;
    logic [15:0]   w_sum_word;
    logic          w_cout;
    logic          w_last;
    logic          w_ovf;

`ifdef MULTIWORD_ADD_SUB_EN
    // Subtraction is a + ~b + 1, so B is inverted once at accept time.
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    // Select the operand words addressed by the current word index.
    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (r_k == KW'(i)) begin
                w_a_word = r_a[16*i +: 16];
                w_b_word = r_b[16*i +: 16];
            end
        end
    end

    ripple_carry_adder_16bit u_adder (
        .A    (w_a_word),
        .B    (w_b_word),
        .Cin  (r_carry),
        .Sum  (w_sum_word),
        .Cout (w_cout)
    );

    assign w_last = (r_k == KW'(NWORDS - 1));
    // Carry into the MSB is recovered from the MSB's own sum bit; only valid
    // while the top word is in the adder.
    assign w_ovf  = w_cout ^ (r_a[W-1] ^ r_b[W-1] ^ w_sum_word[15]);

    // Control FSM plus word-serial datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_sum   <= '0;
                        r_k     <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NWORDS; i++) begin
                        if (r_k == KW'(i)) begin
                            r_sum[16*i +: 16] <= w_sum_word;
                        end
                    end
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_ovf;
                        r_state <= S_HOLD;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_HOLD);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Testbench for multiword_add_sequencer (NWORDS = 4). Results are compared
// against a whole-width arithmetic model. Define MULTIWORD_ADD_SUB_EN to
// exercise the subtract path as well.

module tb_multiword_add_sequencer;

    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;

    multiword_add_sequencer #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef MULTIWORD_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Whole-width reference: {cout,sum} = a + b_eff + c, signed overflow
    // when both operands share a sign the result does not.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mcin, input logic msub,
                         output logic [W-1:0] esum, output logic ecout,
                         output logic eovf);
        logic [W-1:0] beff;
        logic [W:0]   full;
        logic         c;
        beff  = msub ? ~mb : mb;
        c     = msub ? 1'b1 : mcin;
        full  = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, c};
        esum  = full[W-1:0];
        ecout = full[W];
        eovf  = (ma[W-1] == beff[W-1]) && (esum[W-1] != ma[W-1]);
    endtask

    // Issue one request from IDLE, wait (bounded) for out_valid, optionally
    // release the result. Called and returns at posedge+1.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub,
                          input bit release_res,
                          output logic [W-1:0] gsum, output logic gcout,
                          output logic govf, output int lat);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        gsum  = sum;
        gcout = cout;
        govf  = ovf;
        if (release_res) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum got=%h exp=0", sum); end
        n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_directed;
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [W-1:0] gs, es;
        logic gc, go, ec, eo;
        int lat;
        va[0] = 64'h0000_0000_0000_FFFF; vb[0] = 64'h1;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h1;
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h1;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, 1'b0, 1'b1, gs, gc, go, lat);
            model(va[i], vb[i], 1'b0, 1'b0, es, ec, eo);
            n_vec++; if (lat !== NW) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NW); end
            n_vec++; if (gs !== es) begin n_err++; $display("FAIL dir%0d_sum got=%h exp=%h", i, gs, es); end
            n_vec++; if (gc !== ec) begin n_err++; $display("FAIL dir%0d_cout got=%b exp=%b", i, gc, ec); end
            n_vec++; if (go !== eo) begin n_err++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, go, eo); end
        end
        // Explicit constants for the corner cases, independent of the model.
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, gs, gc, go, lat);
        n_vec++; if ({gs, gc, go} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL dir_signed_ovf got=%h/%b/%b exp=8000000000000000/0/1", gs, gc, go);
        end
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, gs, gc, go, lat);
        n_vec++; if (gs !== 64'h0000_0000_0001_0000) begin n_err++; $display("FAIL dir_word_carry got=%h exp=0000000000010000", gs); end
    endtask

    task automatic test_hold_stall;
        logic [W-1:0] gs, es;
        logic gc, go, ec, eo;
        int lat;
        run_op(64'h1234_8000_FFFF_0001, 64'h4321_8000_0001_FFFF, 1'b1, 1'b0, 1'b0, gs, gc, go, lat);
        model(64'h1234_8000_FFFF_0001, 64'h4321_8000_0001_FFFF, 1'b1, 1'b0, es, ec, eo);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            cin = 1'b0;
            @(posedge clk); #1;
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold%0d_out_valid got=%b exp=1", i, out_valid); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_in_ready got=%b exp=0", i, in_ready); end
            n_vec++; if ({sum, cout, ovf} !== {es, ec, eo}) begin
                n_err++; $display("FAIL hold%0d_result got=%h/%b/%b exp=%h/%b/%b", i, sum, cout, ovf, es, ec, eo);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_out_valid got=%b exp=0", out_valid); end
        repeat (NW + 1) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL hold_no_queue got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort;
        logic [W-1:0] gs, es;
        logic gc, go, ec, eo;
        int lat;
        int seen;
        a = 64'hAAAA_BBBB_CCCC_DDDD; b = 64'h1111_2222_3333_4444; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (sum !== '0) begin n_err++; $display("FAIL abort_sum got=%h exp=0", sum); end
        seen = 0;
        for (int i = 0; i < NW + 2; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_result got=%0d exp=0", seen); end
        run_op(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1, 1'b0, 1'b1, gs, gc, go, lat);
        model(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1, 1'b0, es, ec, eo);
        n_vec++; if ({gs, gc, go} !== {es, ec, eo} || lat !== NW) begin
            n_err++; $display("FAIL abort_followup got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=%0d", gs, gc, go, lat, es, ec, eo, NW);
        end
        // Reset beats the output handshake in HOLD.
        run_op(64'h5, 64'h6, 1'b0, 1'b0, 1'b0, gs, gc, go, lat);
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        n_vec++; if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 64'h0}) begin
            n_err++; $display("FAIL rst_prio_hold got=%b/%b/%h exp=1/0/0", in_ready, out_valid, sum);
        end
        // Reset beats the input handshake in IDLE.
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_prio_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_random;
        logic [W-1:0] ra, rb, gs, es;
        logic rc, gc, go, ec, eo;
        int lat;
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 1) ra[47:0] = '1;
            if (i % 4 == 2) rb[W-1] = ra[W-1];
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, 1'b0, 1'b1, gs, gc, go, lat);
            model(ra, rb, rc, 1'b0, es, ec, eo);
            n_vec++; if ({gs, gc, go} !== {es, ec, eo} || lat !== NW) begin
                n_err++; $display("FAIL rand%0d got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=%0d", i, gs, gc, go, lat, es, ec, eo, NW);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ra, rb, gs, es;
        logic gc, go, ec, eo;
        int lat;
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b%0d_ready got=%b exp=1", i, in_ready); end
            run_op(ra, rb, 1'b0, 1'b0, 1'b1, gs, gc, go, lat);
            model(ra, rb, 1'b0, 1'b0, es, ec, eo);
            n_vec++; if ({gs, gc, go} !== {es, ec, eo}) begin
                n_err++; $display("FAIL b2b%0d got=%h/%b/%b exp=%h/%b/%b", i, gs, gc, go, es, ec, eo);
            end
        end
    endtask

`ifdef MULTIWORD_ADD_SUB_EN
    task automatic test_sub;
        logic [W-1:0] ra, rb, gs, es;
        logic gc, go, ec, eo;
        int lat;
        run_op(64'h5, 64'h7, 1'b0, 1'b1, 1'b1, gs, gc, go, lat);
        n_vec++; if ({gs, gc} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0}) begin
            n_err++; $display("FAIL sub_5m7 got=%h/%b exp=fffffffffffffffe/0", gs, gc);
        end
        run_op(64'h7, 64'h5, 1'b1, 1'b1, 1'b1, gs, gc, go, lat);
        n_vec++; if ({gs, gc} !== {64'h2, 1'b1}) begin
            n_err++; $display("FAIL sub_7m5 got=%h/%b exp=2/1", gs, gc);
        end
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_op(ra, rb, 1'b0, 1'b1, 1'b1, gs, gc, go, lat);
            model(ra, rb, 1'b0, 1'b1, es, ec, eo);
            n_vec++; if ({gs, gc, go} !== {es, ec, eo}) begin
                n_err++; $display("FAIL sub_rand%0d got=%h/%b/%b exp=%h/%b/%b", i, gs, gc, go, es, ec, eo);
            end
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        test_reset;
        test_directed;
        test_hold_stall;
        test_abort;
        test_random;
        test_back_to_back;
`ifdef MULTIWORD_ADD_SUB_EN
        test_sub;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
